// File: rtl/jtdd_adpcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtdd_adpcm_pkg
// Description : Shared FSM state encoding and channel ids for the ADPCM
//               ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package jtdd_adpcm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ADDR = 4'b0010,
        ST_WAIT = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/jtdd_adpcm_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtdd_adpcm_arb_if
// Description : Channel request/response and ROM slot signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtdd_adpcm_arb_if #(
    parameter int AW = 16
);
    logic          ch0_req;
    logic          ch1_req;
    logic [AW-1:0] ch0_addr;
    logic [AW-1:0] ch1_addr;
    logic          ch0_ok;
    logic          ch1_ok;
    logic [7:0]    ch0_data;
    logic [7:0]    ch1_data;
    logic          ch0_fail;
    logic          ch1_fail;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          busy;

    // Channels and ROM slot side
    modport master (
        output ch0_req, ch1_req, ch0_addr, ch1_addr, rom_data, rom_ok,
        input  ch0_ok, ch1_ok, ch0_data, ch1_data, ch0_fail, ch1_fail,
        input  rom_addr, rom_cs, busy
    );

    // Arbiter side
    modport slave (
        input  ch0_req, ch1_req, ch0_addr, ch1_addr, rom_data, rom_ok,
        output ch0_ok, ch1_ok, ch0_data, ch1_data, ch0_fail, ch1_fail,
        output rom_addr, rom_cs, busy
    );
endinterface
`default_nettype wire

// File: rtl/jtdd_adpcm_cache.sv
`default_nettype none
// ============================================================================
// Module      : jtdd_adpcm_cache
// Description : One-entry last-byte cache for a single ADPCM channel.
//               Compiled only when JTDD_ADPCM_CACHE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef JTDD_ADPCM_CACHE_EN
module jtdd_adpcm_cache #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    output logic          hit,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [7:0]    fill_data,
    input  logic          inval,
    output logic [7:0]    data
);
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (inval) begin
            r_valid <= 1'b0;
        end else if (fill) begin
            r_valid <= 1'b1;
            r_addr  <= fill_addr;
            r_data  <= fill_data;
        end
    end

    assign hit  = r_valid && (addr == r_addr);
    assign data = r_data;
endmodule
`endif
`default_nettype wire

// File: rtl/jtdd_adpcm_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtdd_adpcm_arb
// Description : Round-robin two-channel ADPCM sample ROM arbiter with per-fetch
//               timeout. Optional per-channel byte cache: JTDD_ADPCM_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jtdd_adpcm_arb
    import jtdd_adpcm_pkg::*;
#(
    parameter int AW = 16,
    parameter int TW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    jtdd_adpcm_arb_if.slave bus
);
    state_t        r_state;
    logic          r_win;
    logic          r_prio;
    logic          r_cs;
    logic [TW-1:0] r_tmo;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_ok;
    logic [1:0]    r_fail;
    logic [7:0]    r_data0;
    logic [7:0]    r_data1;

    logic          w_pick;
    logic [AW-1:0] w_pick_addr;
    logic          w_win_req;
    logic [TW-1:0] w_tmo_nxt;
    logic          w_tmo_end;
    logic          w_hit;
    logic [7:0]    w_hit_data;

    // r_prio names the channel favoured when both request
    assign w_pick      = (bus.ch0_req & bus.ch1_req) ? r_prio : bus.ch1_req;
    assign w_pick_addr = w_pick ? bus.ch1_addr : bus.ch0_addr;
    assign w_win_req   = r_win ? bus.ch1_req : bus.ch0_req;
    assign w_tmo_nxt   = r_tmo + TW'(1);
    assign w_tmo_end   = &w_tmo_nxt;

`ifdef JTDD_ADPCM_CACHE_EN
    logic       w_fill;
    logic       w_inval;
    logic       w_hit0;
    logic       w_hit1;
    logic [7:0] w_cdata0;
    logic [7:0] w_cdata1;

    assign w_fill  = (r_state == ST_WAIT) && bus.rom_ok;
    assign w_inval = (r_state == ST_WAIT) && !bus.rom_ok && w_tmo_end;

    jtdd_adpcm_cache #(.AW(AW)) u_cache0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (bus.ch0_addr),
        .hit       (w_hit0),
        .fill      (w_fill & (r_win == CH0)),
        .fill_addr (r_addr),
        .fill_data (bus.rom_data),
        .inval     (w_inval & (r_win == CH0)),
        .data      (w_cdata0)
    );

    jtdd_adpcm_cache #(.AW(AW)) u_cache1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (bus.ch1_addr),
        .hit       (w_hit1),
        .fill      (w_fill & (r_win == CH1)),
        .fill_addr (r_addr),
        .fill_data (bus.rom_data),
        .inval     (w_inval & (r_win == CH1)),
        .data      (w_cdata1)
    );

    assign w_hit      = w_pick ? w_hit1 : w_hit0;
    assign w_hit_data = w_pick ? w_cdata1 : w_cdata0;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_win   <= CH0;
            r_prio  <= CH0;
            r_cs    <= 1'b0;
            r_tmo   <= '0;
            r_addr  <= '0;
            r_ok    <= 2'b00;
            r_fail  <= 2'b00;
            r_data0 <= 8'h00;
            r_data1 <= 8'h00;
        end else begin
            r_ok <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ch0_req | bus.ch1_req) begin
                        r_win <= w_pick;
                        // A hit bypasses the ROM and leaves rom_addr untouched
                        if (w_hit) begin
                            r_ok[w_pick] <= 1'b1;
                            if (w_pick == CH1) r_data1 <= w_hit_data;
                            else               r_data0 <= w_hit_data;
                            r_state <= ST_DONE;
                        end else begin
                            r_addr  <= w_pick_addr;
                            r_cs    <= 1'b1;
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.rom_ok) begin
                        if (r_win == CH1) r_data1 <= bus.rom_data;
                        else              r_data0 <= bus.rom_data;
                        r_ok[r_win] <= w_win_req;
                        r_cs        <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (w_tmo_end) begin
                        r_fail[r_win] <= 1'b1;
                        r_ok[r_win]   <= w_win_req;
                        r_cs          <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_tmo <= w_tmo_nxt;
                    end
                end
                ST_DONE: begin
                    r_prio  <= ~r_win;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cs    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = r_addr;
    assign bus.rom_cs   = r_cs;
    assign bus.ch0_ok   = r_ok[0];
    assign bus.ch1_ok   = r_ok[1];
    assign bus.ch0_data = r_data0;
    assign bus.ch1_data = r_data1;
    assign bus.ch0_fail = r_fail[0];
    assign bus.ch1_fail = r_fail[1];
    assign bus.busy     = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_jtdd_adpcm_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtdd_adpcm_arb
// Description : Self-checking bench for jtdd_adpcm_arb with a transaction
//               level reference model; follows JTDD_ADPCM_CACHE_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtdd_adpcm_arb;
    localparam int AW  = 16;
    localparam int TW  = 4;
    localparam int TMO = (1 << TW) - 1;
`ifdef JTDD_ADPCM_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  at;
        logic [3:0]  oth;
        logic [7:0]  cs;
        logic [7:0]  d;
        logic        f;
        logic [15:0] ra;
        logic        bz;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtdd_adpcm_arb_if #(.AW(AW)) bus ();

    jtdd_adpcm_arb #(.AW(AW), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM slot: data is a fixed function of the address, rom_ok after a latency
    bit rom_en  = 1'b1;
    int rom_lat = 0;
    int cs_cnt  = 0;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return (a[7:0] ^ a[15:8]) + 8'h7F;
    endfunction

    always @(posedge clk) cs_cnt <= bus.rom_cs ? cs_cnt + 1 : 0;
    assign bus.rom_ok   = rom_en && bus.rom_cs && (cs_cnt >= rom_lat);
    assign bus.rom_data = rom_fn(bus.rom_addr);

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    bit          m_prio;
    logic [7:0]  m_data [2];
    bit          m_fail [2];
    bit          m_cv   [2];
    logic [15:0] m_ca   [2];
    logic [15:0] m_ra;

    task automatic model_reset();
        m_prio = 1'b0;
        m_ra   = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            m_data[c] = 8'h00;
            m_fail[c] = 1'b0;
            m_cv[c]   = 1'b0;
            m_ca[c]   = 16'h0000;
        end
    endtask

    // Expected outcome of granting ch; pre = cycles before its arbitration
    // cycle, cs_pre = rom_cs-high cycles seen in that lead-in.
    task automatic predict(input bit ch, input logic [15:0] addr, input int pre,
                           input int cs_pre, output obs_t e);
        int d;
        int k;
        bit tmo;
        e    = '0;
        e.bz = 1'b1;
        if (CACHE && m_cv[ch] && m_ca[ch] == addr) begin
            d    = 1;
            e.cs = 8'(cs_pre);
        end else begin
            k    = (rom_lat > 1) ? rom_lat - 1 : 0;
            tmo  = !rom_en || (k > TMO - 1);
            d    = tmo ? 2 + TMO : 3 + k;
            e.cs = 8'(cs_pre + d - 1);
            m_ra = addr;
            if (tmo) begin
                m_fail[ch] = 1'b1;
                m_cv[ch]   = 1'b0;
            end else begin
                m_data[ch] = rom_fn(addr);
                m_cv[ch]   = 1'b1;
                m_ca[ch]   = addr;
            end
        end
        e.at   = 8'(pre + d);
        e.d    = m_data[ch];
        e.f    = m_fail[ch];
        e.ra   = m_ra;
        m_prio = ~ch;
    endtask

    // Observe until ch's ok pulse (at=255 when none arrives within bound)
    task automatic watch(input bit ch, input int bound, output obs_t o);
        o    = '0;
        o.at = 8'hFF;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rom_cs) o.cs = o.cs + 8'd1;
            if (ch ? bus.ch0_ok : bus.ch1_ok) o.oth = o.oth + 4'd1;
            if (ch ? bus.ch1_ok : bus.ch0_ok) begin
                o.at = 8'(i);
                o.d  = ch ? bus.ch1_data : bus.ch0_data;
                o.f  = ch ? bus.ch1_fail : bus.ch0_fail;
                o.ra = bus.rom_addr;
                o.bz = bus.busy;
                break;
            end
        end
    endtask

    function automatic string fmt(input obs_t o);
        return $sformatf("ok_at=%0d other_ok=%0d cs_cycles=%0d data=%h fail=%b rom_addr=%h busy=%b",
                         o.at, o.oth, o.cs, o.d, o.f, o.ra, o.bz);
    endfunction

    task automatic set_req(input bit ch, input bit v, input logic [15:0] a);
        if (ch) begin bus.ch1_req = v; bus.ch1_addr = a; end
        else    begin bus.ch0_req = v; bus.ch0_addr = a; end
    endtask

    task automatic drop_req(input bit ch);
        if (ch) bus.ch1_req = 1'b0;
        else    bus.ch0_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic test_reset();
        obs_t o;
        @(negedge clk);
        if ({bus.ch0_ok, bus.ch1_ok, bus.ch0_data, bus.ch1_data, bus.ch0_fail, bus.ch1_fail,
             bus.rom_addr, bus.rom_cs, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_values: ok=%b%b data=%h/%h fail=%b%b rom_addr=%h cs=%b busy=%b, all required 0",
                     bus.ch0_ok, bus.ch1_ok, bus.ch0_data, bus.ch1_data, bus.ch0_fail, bus.ch1_fail,
                     bus.rom_addr, bus.rom_cs, bus.busy);
        end
        vectors++;
        rst_n = 1'b1;
        model_reset();
        watch(1'b0, 3, o);
        if (o.at !== 8'hFF || o.oth !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ok_at=%0d other_ok=%0d busy=%b, required no ok and busy=0", o.at, o.oth, bus.busy);
        end
        vectors++;
    endtask

    task automatic test_contention();
        obs_t o, e;
        logic [15:0] a [2];
        bit ch;
        rom_en  = 1'b1;
        rom_lat = 0;
        a[0] = 16'($urandom);
        a[1] = 16'($urandom);
        set_req(1'b0, 1'b1, a[0]);
        set_req(1'b1, 1'b1, a[1]);
        for (int g = 0; g < 4; g++) begin
            ch = m_prio;
            predict(ch, a[ch], (g == 0) ? 0 : 1, 0, e);
            watch(ch, 40, o);
            if (o !== e) begin
                errors++;
                $display("FAIL contention grant %0d ch%0d: got %s, required %s", g, ch, fmt(o), fmt(e));
            end
            vectors++;
            a[ch] = 16'($urandom);
            set_req(ch, 1'b1, a[ch]);
        end
        drop_req(1'b0);
        drop_req(1'b1);
        idle(1);
    endtask

    task automatic test_single();
        obs_t o, e;
        rom_en  = 1'b1;
        rom_lat = 2;
        set_req(1'b0, 1'b1, 16'h1234);
        predict(1'b0, 16'h1234, 0, 0, e);
        watch(1'b0, 40, o);
        drop_req(1'b0);
        if (o !== e || o.d !== 8'hA5) begin
            errors++;
            $display("FAIL single_ch0: got %s, required %s", fmt(o), fmt(e));
        end
        vectors++;
        idle(1);
    endtask

    task automatic test_timeout();
        obs_t o, e;
        logic [15:0] a;
        rom_en = 1'b0;
        a = 16'($urandom);
        set_req(1'b1, 1'b1, a);
        predict(1'b1, a, 0, 0, e);
        watch(1'b1, 40, o);
        drop_req(1'b1);
        if (o !== e) begin
            errors++;
            $display("FAIL timeout_ch1: got %s, required %s", fmt(o), fmt(e));
        end
        vectors++;
        idle(1);
        rom_en  = 1'b1;
        rom_lat = 1;
        a = 16'($urandom);
        set_req(1'b1, 1'b1, a);
        predict(1'b1, a, 0, 0, e);
        watch(1'b1, 40, o);
        drop_req(1'b1);
        if (o !== e) begin
            errors++;
            $display("FAIL timeout_recover_ch1: got %s, required %s", fmt(o), fmt(e));
        end
        vectors++;
        idle(1);
    endtask

    task automatic test_drop();
        obs_t o, e, e0;
        logic [15:0] a0, b;
        rom_en  = 1'b1;
        rom_lat = 4;
        a0 = 16'($urandom);
        b  = 16'($urandom);
        set_req(1'b0, 1'b1, a0);
        predict(1'b0, a0, 0, 0, e0);
        idle(3);
        drop_req(1'b0);
        set_req(1'b1, 1'b1, b);
        predict(1'b1, b, 4, 2, e);
        watch(1'b1, 40, o);
        drop_req(1'b1);
        if (o !== e) begin
            errors++;
            $display("FAIL drop_then_ch1: got %s, required %s", fmt(o), fmt(e));
        end
        vectors++;
        if (bus.ch0_data !== e0.d) begin
            errors++;
            $display("FAIL drop_ch0_data: got %h, required %h", bus.ch0_data, e0.d);
        end
        vectors++;
        idle(1);
    endtask

    task automatic test_repeat_addr();
        obs_t o, e;
        logic [15:0] seq [3];
        seq[0] = 16'h0040;
        seq[1] = 16'h0040;
        seq[2] = 16'h0041;
        rom_en  = 1'b1;
        rom_lat = 1;
        for (int n = 0; n < 3; n++) begin
            set_req(1'b0, 1'b1, seq[n]);
            predict(1'b0, seq[n], 0, 0, e);
            watch(1'b0, 40, o);
            drop_req(1'b0);
            if (o !== e) begin
                errors++;
                $display("FAIL repeat_addr step %0d addr %h: got %s, required %s", n, seq[n], fmt(o), fmt(e));
            end
            vectors++;
            idle(1);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        logic [15:0] a0, a1;
        rom_en = 1'b0;
        set_req(1'b0, 1'b1, 16'($urandom));
        idle(4);
        rst_n = 1'b0;
        #1;
        if ({bus.ch0_ok, bus.ch1_ok, bus.ch0_data, bus.ch1_data, bus.ch0_fail, bus.ch1_fail,
             bus.rom_addr, bus.rom_cs, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: ok=%b%b data=%h/%h fail=%b%b rom_addr=%h cs=%b busy=%b, all required 0",
                     bus.ch0_ok, bus.ch1_ok, bus.ch0_data, bus.ch1_data, bus.ch0_fail, bus.ch1_fail,
                     bus.rom_addr, bus.rom_cs, bus.busy);
        end
        vectors++;
        drop_req(1'b0);
        idle(2);
        rst_n = 1'b1;
        model_reset();
        watch(1'b0, 5, o);
        if (o.at !== 8'hFF || o.oth !== 4'd0) begin
            errors++;
            $display("FAIL reset_no_ok: ok_at=%0d other_ok=%0d, required none", o.at, o.oth);
        end
        vectors++;
        rom_en  = 1'b1;
        rom_lat = 1;
        a0 = 16'($urandom);
        a1 = 16'($urandom);
        set_req(1'b0, 1'b1, a0);
        set_req(1'b1, 1'b1, a1);
        predict(1'b0, a0, 0, 0, e);
        watch(1'b0, 40, o);
        drop_req(1'b0);
        if (o !== e) begin
            errors++;
            $display("FAIL reset_prio_ch0: got %s, required %s", fmt(o), fmt(e));
        end
        vectors++;
        predict(1'b1, a1, 1, 0, e);
        watch(1'b1, 40, o);
        drop_req(1'b1);
        if (o !== e) begin
            errors++;
            $display("FAIL reset_then_ch1: got %s, required %s", fmt(o), fmt(e));
        end
        vectors++;
        idle(1);
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [15:0] a [2];
        int mask;
        bit first;
        for (int it = 0; it < 30; it++) begin
            mask    = $urandom_range(1, 3);
            a[0]    = 16'h0100 + 16'($urandom_range(0, 3));
            a[1]    = 16'h0100 + 16'($urandom_range(0, 3));
            rom_lat = $urandom_range(0, 5);
            rom_en  = ($urandom_range(0, 7) != 0);
            first   = (mask == 3) ? m_prio : (mask == 2);
            if (mask[0]) set_req(1'b0, 1'b1, a[0]);
            if (mask[1]) set_req(1'b1, 1'b1, a[1]);
            predict(first, a[first], 0, 0, e);
            watch(first, 40, o);
            drop_req(first);
            if (o !== e) begin
                errors++;
                $display("FAIL random it %0d ch%0d: got %s, required %s", it, first, fmt(o), fmt(e));
            end
            vectors++;
            if (mask == 3) begin
                predict(~first, a[~first], 1, 0, e);
                watch(~first, 40, o);
                drop_req(~first);
                if (o !== e) begin
                    errors++;
                    $display("FAIL random it %0d second ch%0d: got %s, required %s", it, ~first, fmt(o), fmt(e));
                end
                vectors++;
            end
            idle(1);
        end
        if (bus.busy !== 1'b0 || bus.rom_cs !== 1'b0) begin
            errors++;
            $display("FAIL final_idle: busy=%b rom_cs=%b, required 0/0", bus.busy, bus.rom_cs);
        end
        vectors++;
    endtask

    initial begin
        bus.ch0_req  = 1'b0;
        bus.ch1_req  = 1'b0;
        bus.ch0_addr = '0;
        bus.ch1_addr = '0;
        model_reset();
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_drop();
        test_repeat_addr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/jtdd_adpcm_arb.md
# jtdd_adpcm_arb

Two-channel ROM arbiter for the Double Dragon ADPCM sound path. Both MSM5205-style decoder channels share one 8-bit ADPCM sample ROM port. This block serializes their byte fetches with round-robin priority and a per-fetch timeout. It sits between the two channel address generators and the SDRAM-backed ROM slot.

## Interface
- `AW`, 16, ROM byte address width
- `TW`, 8, timeout counter width; a fetch is abandoned after 2^TW−1 WAIT cycles
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `ch0_req`, `ch1_req` in 1: level request; held until matching `chN_ok` pulse
- `ch0_addr`, `ch1_addr` in AW: byte address, stable while `chN_req` high
- `ch0_ok`, `ch1_ok` out 1: one-cycle pulse, `chN_data` valid that cycle and held after
- `ch0_data`, `ch1_data` out 8: last byte returned to channel
- `ch0_fail`, `ch1_fail` out 1: sticky timeout flag; cleared by reset only
- `rom_addr` out AW: ROM address
- `rom_cs` out 1: ROM request
- `rom_data` in 8: ROM data
- `rom_ok` in 1: ROM data valid for current `rom_addr` (may be stale for one cycle after address change)
- `busy` out 1: FSM not in IDLE

## Operation
- FSM states: IDLE, ADDR, WAIT, DONE. One-hot encoding.
- IDLE: if any req, pick a winner. When both request, the winner is the channel not granted last. After reset ch0 has priority. Latch the winner id and address into `rom_addr`, assert `rom_cs`, go to ADDR.
- ADDR: one settle cycle; `rom_ok` ignored. Go to WAIT and clear the timeout counter.
- WAIT: on `rom_ok`, latch `rom_data` into the winner's data register and go to DONE. Otherwise increment the timeout. At all-ones, set `chN_fail`, leave data unchanged, go to DONE.
- DONE: pulse `chN_ok` if `chN_req` is still high. Always drop `rom_cs`, flip the round-robin pointer to favour the other channel, and return to IDLE.
- Request dropped mid-fetch: the fetch completes, data is latched, and no `ok` pulse is issued.
- Address change while req high is a protocol error; the latched address is used.
- `rom_addr` holds its last value in IDLE.
- Reset values: `rom_cs`=0, `rom_addr`=0, `chN_ok`=0, `chN_data`=0, `chN_fail`=0, `busy`=0, pointer favours ch0, state IDLE.
- Reset asserted mid-fetch aborts immediately. No ok pulse follows reset release.

## Timing
- Miss latency: req sampled high in IDLE at cycle T. ADDR is T+1, WAIT from T+2. With `rom_ok` at T+2, `ok` pulses at T+3.
- Minimum req-to-ok is 3 cycles.
- Back-to-back: the next grant is decided in the IDLE cycle after DONE. Peak throughput is one byte per 4 cycles.
- Both channels requesting continuously get strictly alternating grants.
- Timeout: `fail` and the DONE pulse occur 2^TW−1 cycles after WAIT entry.
- `rom_cs` is high from ADDR through WAIT and low in DONE and IDLE.

## Configuration
- `JTDD_ADPCM_CACHE_EN` defined:
  - Each channel keeps its last fetched address and byte, plus a valid bit. Valid is cleared by reset and by a timeout.
  - In IDLE, a winning request whose address matches a valid cache entry is a hit. The hit skips ADDR and WAIT and goes straight to DONE, so `ok` pulses at T+1.
  - A hit does not touch `rom_cs` or `rom_addr`, and it counts as a grant for round-robin.
- Macro undefined: no cache; every request is a ROM fetch.

## Structure
- Package `jtdd_adpcm_pkg`: FSM state constants and the channel-id constants CH0/CH1.
- Sub-module `jtdd_adpcm_cache`, one instance per channel, compiled only under `JTDD_ADPCM_CACHE_EN`. Ports: clk, rst_n, addr, hit, fill, fill_addr, fill_data, inval, data.

## Test plan
- Single ch0 fetch: ch0_addr=16'h1234, `rom_ok` returned 2 cycles after `rom_cs` rises with data 8'hA5 → `rom_addr`=16'h1234, ch0_ok pulses once, ch0_data=8'hA5, ch1_ok never pulses.
- Contention: ch0 and ch1 req high together continuously, `rom_ok` always high → grant order ch0, ch1, ch0, ch1; each ok arrives 4 cycles apart.
- Timeout, TW=4: ch1 req, `rom_ok` held low → ch1_fail=1 after 15 WAIT cycles, ch1_ok pulses, ch1_data unchanged, the next ch1 request is served normally.
- Dropped request: ch0 req falls during WAIT → no ch0_ok pulse, FSM returns to IDLE, ch1 is served next.
- Reset mid-fetch: assert `rst_n`=0 during WAIT → all outputs 0 asynchronously; after release, no spurious ok and ch0 has priority.
- Cache (macro on): ch0 fetches 16'h0040, then requests 16'h0040 again → ok pulses 1 cycle after req with `rom_cs` staying 0. A request to 16'h0041 triggers a ROM fetch.
